// File: rtl/kv_mem_read_arbiter_if.sv
// Bundle of the two requester read ports and the shared memory read channel.
// The slave view belongs to the arbiter; the master view is the environment
// (requesters and memory) that surrounds it.
interface kv_mem_read_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // Port 0: instruction fetch
  logic                  i_rd0_valid;
  logic [ADDR_WIDTH-1:0] i_rd0_addr;
  logic                  o_rd0_ready;
  logic [DATA_WIDTH-1:0] o_rd0_data;
  logic                  o_rd0_valid;
  logic                  i_rd0_ready;
  // Port 1: load/store unit
  logic                  i_rd1_valid;
  logic [ADDR_WIDTH-1:0] i_rd1_addr;
  logic                  o_rd1_ready;
  logic [DATA_WIDTH-1:0] o_rd1_data;
  logic                  o_rd1_valid;
  logic                  i_rd1_ready;
  // Shared memory read channel
  logic                  o_mem_read_valid;
  logic [ADDR_WIDTH-1:0] o_mem_read_addr;
  logic                  i_mem_read_ready;
  logic [DATA_WIDTH-1:0] i_mem_read_data;
  logic                  i_mem_read_valid;
  logic                  o_mem_read_ready;

  modport slave (
    input  i_rd0_valid, i_rd0_addr, i_rd0_ready,
    input  i_rd1_valid, i_rd1_addr, i_rd1_ready,
    input  i_mem_read_ready, i_mem_read_data, i_mem_read_valid,
    output o_rd0_ready, o_rd0_data, o_rd0_valid,
    output o_rd1_ready, o_rd1_data, o_rd1_valid,
    output o_mem_read_valid, o_mem_read_addr, o_mem_read_ready
  );

  modport master (
    output i_rd0_valid, i_rd0_addr, i_rd0_ready,
    output i_rd1_valid, i_rd1_addr, i_rd1_ready,
    output i_mem_read_ready, i_mem_read_data, i_mem_read_valid,
    input  o_rd0_ready, o_rd0_data, o_rd0_valid,
    input  o_rd1_ready, o_rd1_data, o_rd1_valid,
    input  o_mem_read_valid, o_mem_read_addr, o_mem_read_ready
  );
endinterface

// File: rtl/kv_mem_read_arbiter.sv
// Two-port round-robin read arbiter in front of the single KVMemory read port.
// One transaction in flight: IDLE accepts, REQ presents the address to memory,
// RESP steers the memory response straight through to the owning requester.
module kv_mem_read_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic                  i_clk,
  input logic                  i_rst,
  kv_mem_read_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t                state_reg;
  logic                  owner_reg;
  logic                  last_grant_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;

  logic [1:0]            req_valid;
  logic [1:0]            rsp_ready;
  logic [ADDR_WIDTH-1:0] req_addr [2];
  logic [1:0]            grant;
  logic                  winner;

  logic                  port_ready [2];
  logic                  port_valid [2];
  logic [DATA_WIDTH-1:0] port_data  [2];

  assign req_valid   = {bus.i_rd1_valid, bus.i_rd0_valid};
  assign rsp_ready   = {bus.i_rd1_ready, bus.i_rd0_ready};
  assign req_addr[0] = bus.i_rd0_addr;
  assign req_addr[1] = bus.i_rd1_addr;

  // Winner selection: a lone requester wins; on a tie the port that was not granted last wins.
  always_comb begin
    grant    = 2'b00;
    grant[0] = req_valid[0] && (!req_valid[1] || last_grant_reg);
    grant[1] = req_valid[1] && (!req_valid[0] || !last_grant_reg);
  end

  assign winner = grant[1];

  // Transaction FSM: accept in IDLE, wait for memory accept in REQ, wait for delivered response in RESP.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      addr_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|grant) begin
            addr_reg       <= req_addr[winner];
            owner_reg      <= winner;
            last_grant_reg <= winner;
            state_reg      <= REQ;
          end
        end
        REQ: begin
          if (bus.i_mem_read_ready) state_reg <= RESP;
        end
        RESP: begin
          if (bus.i_mem_read_valid && rsp_ready[owner_reg]) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      // Per-port view: ready only for the IDLE winner, response only for the owner in RESP.
      always_comb begin
        port_ready[gi] = 1'b0;
        port_valid[gi] = 1'b0;
        port_data[gi]  = '0;
        if (!i_rst) begin
          if (state_reg == IDLE) port_ready[gi] = grant[gi];
          if (state_reg == RESP && owner_reg == 1'(gi)) begin
            port_valid[gi] = bus.i_mem_read_valid;
            port_data[gi]  = bus.i_mem_read_data;
          end
        end
      end
    end
  endgenerate

  assign bus.o_rd0_ready = port_ready[0];
  assign bus.o_rd0_valid = port_valid[0];
  assign bus.o_rd0_data  = port_data[0];
  assign bus.o_rd1_ready = port_ready[1];
  assign bus.o_rd1_valid = port_valid[1];
  assign bus.o_rd1_data  = port_data[1];

  // Memory side is driven only from the held request and the owner's response readiness.
  assign bus.o_mem_read_valid = !i_rst && (state_reg == REQ);
  assign bus.o_mem_read_addr  = (!i_rst && state_reg == REQ) ? addr_reg : '0;
  assign bus.o_mem_read_ready = !i_rst && (state_reg == RESP) && rsp_ready[owner_reg];

endmodule

// File: tb/tb_kv_mem_read_arbiter.sv
// Bench for kv_mem_read_arbiter: a cycle-by-cycle vector table covering reset,
// single-port, contention, stall and backpressure cases, followed by a
// scoreboarded run of randomised requests against a simple memory model.
module tb_kv_mem_read_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  kv_mem_read_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  kv_mem_read_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic        v0;
    logic [31:0] a0;
    logic        v1;
    logic [31:0] a1;
    logic        rr0;
    logic        rr1;
    logic        mr;
    logic        mv;
    logic [31:0] md;
    logic        e_r0;
    logic        e_r1;
    logic        e_v0;
    logic [31:0] e_d0;
    logic        e_v1;
    logic [31:0] e_d1;
    logic        e_mv;
    logic [31:0] e_ma;
    logic        e_mr;
  } vec_t;

  typedef struct {
    logic        port;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   vectors    = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic r, input logic v0, input logic [31:0] a0,
                     input logic v1, input logic [31:0] a1, input logic rr0, input logic rr1,
                     input logic mr, input logic mv, input logic [31:0] md,
                     input logic er0, input logic er1, input logic ev0, input logic [31:0] ed0,
                     input logic ev1, input logic [31:0] ed1, input logic emv,
                     input logic [31:0] ema, input logic emr);
    vec_t v;
    v.name = name; v.rst = r; v.v0 = v0; v.a0 = a0; v.v1 = v1; v.a1 = a1;
    v.rr0 = rr0; v.rr1 = rr1; v.mr = mr; v.mv = mv; v.md = md;
    v.e_r0 = er0; v.e_r1 = er1; v.e_v0 = ev0; v.e_d0 = ed0; v.e_v1 = ev1; v.e_d1 = ed1;
    v.e_mv = emv; v.e_ma = ema; v.e_mr = emr;
    vecs.push_back(v);
  endtask

  task automatic clear_inputs();
    rst = 1'b0;
    bus.i_rd0_valid = 1'b0; bus.i_rd0_addr = '0; bus.i_rd0_ready = 1'b0;
    bus.i_rd1_valid = 1'b0; bus.i_rd1_addr = '0; bus.i_rd1_ready = 1'b0;
    bus.i_mem_read_ready = 1'b0; bus.i_mem_read_data = '0; bus.i_mem_read_valid = 1'b0;
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Watchdog so a wedged run still ends with a visible failure.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] maddr;
    logic        lg;
    logic        u0, u1, win;
    logic [1:0]  sel;
    int          stall, bp;
    exp_t        e;

    //   name          rst v0 a0       v1 a1        rr0 rr1 mr mv md            r0 r1 v0o d0            v1o d1            mvo ma       mro
    add("rst_idle",    1, 0, 0,       0, 0,        0, 0, 0, 0, 0,             0, 0, 0, 0,             0, 0,             0, 0,       0);
    add("rst_force",   1, 1, 32'h4,   1, 32'h8,    1, 1, 1, 1, 32'hFFFF,      0, 0, 0, 0,             0, 0,             0, 0,       0);
    add("post_rst",    0, 0, 0,       0, 0,        0, 0, 0, 0, 0,             0, 0, 0, 0,             0, 0,             0, 0,       0);
    add("p0_acc",      0, 1, 32'h4,   0, 0,        0, 0, 0, 0, 0,             1, 0, 0, 0,             0, 0,             0, 0,       0);
    add("p0_req",      0, 1, 32'h4,   0, 0,        0, 0, 1, 0, 0,             0, 0, 0, 0,             0, 0,             1, 32'h4,   0);
    add("p0_resp",     0, 0, 0,       0, 0,        1, 0, 0, 1, 32'hDEADBEEF,  0, 0, 1, 32'hDEADBEEF,  0, 0,             0, 0,       1);
    add("p0_idle",     0, 0, 0,       0, 0,        0, 0, 0, 0, 0,             0, 0, 0, 0,             0, 0,             0, 0,       0);
    add("rr_rst",      1, 0, 0,       0, 0,        0, 0, 0, 0, 0,             0, 0, 0, 0,             0, 0,             0, 0,       0);
    add("rr_g0",       0, 1, 32'h10,  1, 32'h20,   0, 0, 0, 0, 0,             1, 0, 0, 0,             0, 0,             0, 0,       0);
    add("rr_m0",       0, 1, 32'h10,  1, 32'h20,   0, 0, 1, 0, 0,             0, 0, 0, 0,             0, 0,             1, 32'h10,  0);
    add("rr_d0",       0, 1, 32'h10,  1, 32'h20,   1, 1, 0, 1, 32'hA0,        0, 0, 1, 32'hA0,        0, 0,             0, 0,       1);
    add("rr_g1",       0, 1, 32'h10,  1, 32'h20,   0, 0, 0, 0, 0,             0, 1, 0, 0,             0, 0,             0, 0,       0);
    add("rr_m1",       0, 1, 32'h10,  1, 32'h20,   0, 0, 1, 0, 0,             0, 0, 0, 0,             0, 0,             1, 32'h20,  0);
    add("rr_d1",       0, 1, 32'h10,  1, 32'h20,   1, 1, 0, 1, 32'hA1,        0, 0, 0, 0,             1, 32'hA1,        0, 0,       1);
    add("rr_g2",       0, 1, 32'h10,  1, 32'h20,   0, 0, 0, 0, 0,             1, 0, 0, 0,             0, 0,             0, 0,       0);
    add("rr_m2",       0, 1, 32'h10,  1, 32'h20,   0, 0, 1, 0, 0,             0, 0, 0, 0,             0, 0,             1, 32'h10,  0);
    add("rr_d2",       0, 1, 32'h10,  1, 32'h20,   1, 1, 0, 1, 32'hA2,        0, 0, 1, 32'hA2,        0, 0,             0, 0,       1);
    add("rr_g3",       0, 1, 32'h10,  1, 32'h20,   0, 0, 0, 0, 0,             0, 1, 0, 0,             0, 0,             0, 0,       0);
    add("rr_m3",       0, 1, 32'h10,  1, 32'h20,   0, 0, 1, 0, 0,             0, 0, 0, 0,             0, 0,             1, 32'h20,  0);
    add("rr_d3",       0, 1, 32'h10,  1, 32'h20,   1, 1, 0, 1, 32'hA3,        0, 0, 0, 0,             1, 32'hA3,        0, 0,       1);
    add("st_acc",      0, 1, 32'h44,  0, 0,        0, 0, 0, 0, 0,             1, 0, 0, 0,             0, 0,             0, 0,       0);
    for (int i = 0; i < 4; i++)
      add("st_wait",   0, 0, 0,       1, 32'h88,   0, 0, 0, 0, 0,             0, 0, 0, 0,             0, 0,             1, 32'h44,  0);
    add("st_go",       0, 0, 0,       1, 32'h88,   0, 0, 1, 0, 0,             0, 0, 0, 0,             0, 0,             1, 32'h44,  0);
    add("st_resp",     0, 0, 0,       1, 32'h88,   1, 0, 0, 1, 32'h55,        0, 0, 1, 32'h55,        0, 0,             0, 0,       1);
    add("bp_acc",      0, 0, 0,       1, 32'h88,   0, 0, 0, 0, 0,             0, 1, 0, 0,             0, 0,             0, 0,       0);
    add("bp_req",      0, 0, 0,       0, 0,        0, 0, 1, 0, 0,             0, 0, 0, 0,             0, 0,             1, 32'h88,  0);
    add("bp_nov",      0, 0, 0,       0, 0,        0, 1, 0, 0, 0,             0, 0, 0, 0,             0, 0,             0, 0,       1);
    for (int i = 0; i < 3; i++)
      add("bp_hold",   0, 0, 0,       0, 0,        1, 0, 0, 1, 32'h12345678,  0, 0, 0, 0,             1, 32'h12345678,  0, 0,       0);
    add("bp_done",     0, 0, 0,       0, 0,        0, 1, 0, 1, 32'h12345678,  0, 0, 0, 0,             1, 32'h12345678,  0, 0,       1);
    add("rs_acc",      0, 0, 0,       1, 32'h99,   0, 0, 0, 0, 0,             0, 1, 0, 0,             0, 0,             0, 0,       0);
    add("rs_req",      0, 0, 0,       0, 0,        0, 0, 1, 0, 0,             0, 0, 0, 0,             0, 0,             1, 32'h99,  0);
    add("rs_resp",     0, 0, 0,       0, 0,        0, 0, 0, 1, 32'h77,        0, 0, 0, 0,             1, 32'h77,        0, 0,       0);
    add("rs_rst",      1, 0, 0,       0, 0,        0, 1, 0, 1, 32'hBAD,       0, 0, 0, 0,             0, 0,             0, 0,       0);
    add("rs_after",    0, 0, 0,       0, 0,        0, 1, 0, 1, 32'h77,        0, 0, 0, 0,             0, 0,             0, 0,       0);
    add("fr_acc",      0, 0, 0,       1, 32'h30,   0, 0, 0, 0, 0,             0, 1, 0, 0,             0, 0,             0, 0,       0);
    add("fr_req",      0, 0, 0,       0, 0,        0, 0, 1, 0, 0,             0, 0, 0, 0,             0, 0,             1, 32'h30,  0);
    add("fr_resp",     0, 0, 0,       0, 0,        0, 1, 0, 1, 32'hCAFEF00D,  0, 0, 0, 0,             1, 32'hCAFEF00D,  0, 0,       1);
    add("fr_idle",     0, 0, 0,       0, 0,        0, 0, 0, 0, 0,             0, 0, 0, 0,             0, 0,             0, 0,       0);

    clear_inputs();
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst                  = vecs[i].rst;
      bus.i_rd0_valid      = vecs[i].v0;
      bus.i_rd0_addr       = vecs[i].a0;
      bus.i_rd1_valid      = vecs[i].v1;
      bus.i_rd1_addr       = vecs[i].a1;
      bus.i_rd0_ready      = vecs[i].rr0;
      bus.i_rd1_ready      = vecs[i].rr1;
      bus.i_mem_read_ready = vecs[i].mr;
      bus.i_mem_read_valid = vecs[i].mv;
      bus.i_mem_read_data  = vecs[i].md;
      #1;
      check(vecs[i].name,
            {26'd0, bus.o_rd0_ready, bus.o_rd1_ready, bus.o_rd0_valid, bus.o_rd0_data,
             bus.o_rd1_valid, bus.o_rd1_data, bus.o_mem_read_valid, bus.o_mem_read_addr,
             bus.o_mem_read_ready},
            {26'd0, vecs[i].e_r0, vecs[i].e_r1, vecs[i].e_v0, vecs[i].e_d0,
             vecs[i].e_v1, vecs[i].e_d1, vecs[i].e_mv, vecs[i].e_ma, vecs[i].e_mr});
    end

    // Scoreboarded run: random mix of single and contending requests, random stalls.
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    clear_inputs();
    lg = 1'b1;
    for (int t = 0; t < 12; t++) begin
      sel = 2'($urandom_range(1, 3));
      u0  = sel[0];
      u1  = sel[1];
      bus.i_rd0_valid = u0;
      bus.i_rd0_addr  = 32'h100 + 32'(t * 16);
      bus.i_rd1_valid = u1;
      bus.i_rd1_addr  = 32'h200 + 32'(t * 16);
      win = (u0 && u1) ? !lg : u1;
      lg  = win;
      e.port = win;
      e.addr = win ? bus.i_rd1_addr : bus.i_rd0_addr;
      e.data = memf(e.addr);
      sb.push_back(e);
      #1;
      check("sb_grant", {126'd0, bus.o_rd1_ready, bus.o_rd0_ready}, win ? 128'd2 : 128'd1);

      stall = $urandom_range(0, 2);
      maddr = '0;
      for (int s = 0; s <= stall; s++) begin
        @(negedge clk);
        clear_inputs();
        bus.i_mem_read_ready = (s == stall);
        #1;
        if (s == stall) begin
          maddr = bus.o_mem_read_addr;
          check("sb_addr", {95'd0, bus.o_mem_read_valid, bus.o_mem_read_addr},
                {95'd0, 1'b1, sb[0].addr});
        end
      end

      bp = $urandom_range(0, 2);
      for (int s = 0; s <= bp; s++) begin
        @(negedge clk);
        clear_inputs();
        bus.i_mem_read_valid = 1'b1;
        bus.i_mem_read_data  = memf(maddr);
        if (win) bus.i_rd1_ready = (s == bp);
        else     bus.i_rd0_ready = (s == bp);
        #1;
        if (s == bp) begin
          e = sb.pop_front();
          check("sb_resp",
                {61'd0, bus.o_rd0_valid, bus.o_rd0_data, bus.o_rd1_valid, bus.o_rd1_data,
                 bus.o_mem_read_ready},
                e.port ? {61'd0, 1'b0, 32'd0, 1'b1, e.data, 1'b1}
                       : {61'd0, 1'b1, e.data, 1'b0, 32'd0, 1'b1});
        end else begin
          check("sb_bp", {127'd0, bus.o_mem_read_ready}, 128'd0);
        end
      end
      @(negedge clk);
      clear_inputs();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/kv_mem_read_arbiter.md
# kv_mem_read_arbiter

Two-requester read arbiter that shares the single KVMemory read port between instruction fetch (port 0) and the load/store unit (port 1).
- Accepts one request at a time, forwards it on the memory read channel, and routes the response back to the owning requester.
- Keeps exactly one transaction outstanding.
- Alternates grants round-robin under contention.

## Interface
Parameters:
- ADDR_WIDTH, 32, read address width
- DATA_WIDTH, 32, read data width

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_rd0_valid  in  1  port 0 request valid
- i_rd0_addr  in  ADDR_WIDTH  port 0 request address
- o_rd0_ready  out  1  port 0 request accepted this cycle when high with i_rd0_valid
- o_rd0_data  out  DATA_WIDTH  port 0 response data
- o_rd0_valid  out  1  port 0 response valid
- i_rd0_ready  in  1  port 0 can take response
- i_rd1_valid, i_rd1_addr, o_rd1_ready, o_rd1_data, o_rd1_valid, i_rd1_ready: same as port 0, for port 1
- o_mem_read_valid  out  1  request valid to memory
- o_mem_read_addr  out  ADDR_WIDTH  request address to memory
- i_mem_read_ready  in  1  memory accepts request
- i_mem_read_data  in  DATA_WIDTH  memory response data
- i_mem_read_valid  in  1  memory response valid
- o_mem_read_ready  out  1  arbiter can take memory response

## Operation
State machine: IDLE, REQ, RESP. Registers: state, owner (1 bit), addr_q, last_grant (1 bit).

IDLE:
- Winner rule:
  - Only one port valid: that port wins.
  - Both ports valid: the port != last_grant wins.
- o_rdW_ready=1 for the winner only; it is combinational from the valid inputs.
- On accept:
  - addr_q <= winner address, owner <= W, last_grant <= W.
  - Go to REQ.

REQ:
- o_mem_read_valid=1, o_mem_read_addr=addr_q.
- Both o_rdk_ready are 0.
- On i_mem_read_ready=1, go to RESP.

RESP:
- o_rd{owner}_valid = i_mem_read_valid; o_rd{owner}_data = i_mem_read_data; both are combinational pass-through.
- o_mem_read_ready = i_rd{owner}_ready.
- On i_mem_read_valid & i_rd{owner}_ready, go to IDLE.
- The non-owner port sees o_rdk_valid=0 and o_rdk_ready=0.

General:
- o_rdk_data for a non-owner port = 0.
- Addresses are passed through unmodified; there is no arithmetic on them.
- A requester may hold or drop valid while not granted; the arbiter does not latch an unaccepted request.

## Timing
Reset (i_rst high at an edge):
- state=IDLE, last_grant=1 (port 0 wins the first tie), owner=0, addr_q=0.
- While i_rst is high, all outputs are forced to 0: o_rdk_ready, o_rdk_valid, o_rdk_data, o_mem_read_valid, o_mem_read_addr, o_mem_read_ready.

Reset mid-transaction (REQ or RESP):
- Transaction is abandoned and state returns to IDLE; no response is forwarded.
- Memory-side cleanup belongs to the memory's own reset.

Latency:
- Requester accept in cycle N.
- o_mem_read_valid high from cycle N+1 until i_mem_read_ready.
- Response reaches the requester in the same cycle memory presents it (0 added cycles).
- Minimum turnaround: accept at N, memory ready at N+1, response at N+2, next accept at N+3. Maximum throughput is one transaction per 3 cycles.

Stalls:
- Memory ready low: REQ holds with address stable.
- Requester response ready low: RESP holds and backpressures memory through o_mem_read_ready.

Simultaneous valid in IDLE: exactly one ready is asserted, never both.

## Test plan
- Reset, both valids low → all outputs 0; after release, state IDLE and no ready asserted.
- Port 0 only, addr 0x0000_0004, memory ready immediately, data 0xDEAD_BEEF one cycle later → o_rd0_ready pulses at N; o_mem_read_addr=0x4 valid at N+1; o_rd0_valid/data=0xDEAD_BEEF at N+2; port 1 outputs stay 0.
- Both ports valid continuously (port 0 addr 0x10, port 1 addr 0x20) → grants alternate 0,1,0,1 with memory addresses 0x10,0x20,0x10,0x20; each response goes only to its owner.
- Memory ready held low 4 cycles in REQ → o_mem_read_valid and addr stay constant for 5 cycles; no new request accepted.
- Owner i_rd1_ready low 3 cycles while memory response valid (data 0x1234_5678) → o_mem_read_ready low and state held; transfer completes on the cycle i_rd1_ready rises.
- i_rst asserted during RESP → next cycle all outputs 0 and state IDLE; a fresh port 1 request after release is accepted normally.
